mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store unit for the pipelined MIPS core, sitting between the EX/MEM pipeline register and the word-organised `Data_memory`. It converts byte addresses to word indices, performs byte/halfword/word loads with sign or zero extension, and implements SB/SH as read-modify-write sequences. Because `Data_memory` returns read data one clock after the address is presented, loads and sub-word stores stall the pipeline while this unit runs its sequence.

## Interface
- `DEPTH`, 1024, number of 32-bit words in the data memory; must be a power of two.
- `Clk` in 1: rising-edge clock shared with `Data_memory`.
- `Rst_n` in 1: asynchronous, active-low reset.
- `MemReq` in 1: EX/MEM holds a memory operation this cycle.
- `MemOp` in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 110 SB, 111 SH, 011 SW.
- `Addr` in 32: byte address.
- `StoreData` in 32: store source (rt).
- `Stall` out 1: freeze upstream stages and hold `MemReq`/`MemOp`/`Addr`/`StoreData` stable.
- `LoadData` out 32: extended load result, registered.
- `LoadValid` out 1: `LoadData` is valid for the operation completing this cycle.
- `AlignErr` out 1: misaligned access rejected.
- `DmemAddr` out 32: word index to `Data_memory`.
- `DmemWrite` out 1: write strobe to `Data_memory`.
- `DmemWrData` out 32: write word to `Data_memory`.
- `DmemRdData` in 32: registered read word from `Data_memory`.

## Operation
- Word index: `DmemAddr = {zeros, Addr[log2(DEPTH)+1:2]}`. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Byte lanes are little-endian:
  - `Addr[1:0]`=0 selects bits [7:0] and 3 selects [31:24].
  - Halfword `Addr[1]`=0 selects [15:0] and 1 selects [31:16].
- FSM states are IDLE, RD_WAIT and DONE. The unit latches op, address and store data on leaving IDLE.
- **IDLE, no `MemReq`:** no access; `DmemWrite`=0.
- **IDLE, SW:** `DmemWrite`=1 and `DmemWrData`=`StoreData` in the same cycle. `Stall`=0 and the FSM stays in IDLE.
- **IDLE, load/SB/SH:** `DmemAddr` is driven with `DmemWrite`=0. `Stall`=1 and the FSM moves to RD_WAIT.
- **RD_WAIT, load:**
  - Extract the lane from `DmemRdData`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Register the result into `LoadData`.
  - `Stall`=1; next state DONE.
- **RD_WAIT, SB/SH:**
  - `DmemWrData` = `DmemRdData` with the selected lane replaced by `StoreData[7:0]` or `StoreData[15:0]`.
  - `DmemWrite`=1 and `DmemAddr` = latched index.
  - `Stall`=1; next state DONE.
- **DONE:** `Stall`=0, and `LoadValid`=1 if the op was a load. `MemReq` is ignored in this state, since it still carries the finished op. Next state IDLE.
- **Misaligned access** (LW/SW with `Addr[1:0]`≠0, LH/LHU/SH with `Addr[0]`=1):
  - Handled in IDLE: `AlignErr`=1 for that cycle, no memory access, `Stall`=0.
  - `LoadData` is unchanged; the FSM stays in IDLE.
- An undefined `MemOp` cannot occur: all 8 codes are assigned.

## Timing
- Reset values, and values held while `Rst_n`=0:
  - state IDLE
  - `LoadData`=0, `LoadValid`=0, `AlignErr`=0, `Stall`=0
  - `DmemWrite`=0, `DmemAddr`=0, `DmemWrData`=0
- `Stall`, `DmemWrite`, `DmemAddr`, `DmemWrData` and `AlignErr` are combinational from state plus inputs. `LoadData` is registered.
- Cycle counts:
  - SW: 1 cycle, no stall.
  - Load: 3 cycles (IDLE→RD_WAIT→DONE), `Stall` high for 2.
  - SB/SH: 3 cycles, with the write committed at the RD_WAIT→DONE edge.
- Back-to-back operations: a new request is accepted only in IDLE, one cycle after DONE.
- Reset asserted mid-sequence: the FSM goes to IDLE at once and no partial write is issued. A RMW caught in RD_WAIT is abandoned and memory is unchanged.

## Configuration
- `MAU_ALIGN_CHECK_EN` defined:
  - Misaligned accesses are rejected as described under Operation, with `AlignErr` asserted.
- `MAU_ALIGN_CHECK_EN` undefined:
  - `AlignErr` is tied to 0.
  - Low address bits below the access size are forced to 0: word ops use the aligned word, halfword ops ignore `Addr[0]`.
  - The operation proceeds normally.

## Test plan
- Word 5 = 0x8899AABB. LB at `Addr`=0x15 → `DmemAddr`=5, `Stall` high for 2 cycles, `LoadData`=0xFFFFFFAA with `LoadValid` in DONE. LBU at the same address → 0x000000AA.
- Word 2 = 0x11223344. SH `StoreData`=0xCAFE at `Addr`=0x0A → word 2 = 0xCAFE3344 after 3 cycles. LH at the same address then returns 0xFFFFCAFE.
- SW 0xDEADBEEF at `Addr`=0x40 → `DmemWrite`=1 in the same cycle, `Stall`=0, word 16 = 0xDEADBEEF.
- With `MAU_ALIGN_CHECK_EN`: LW at `Addr`=0x42 → `AlignErr` high for 1 cycle, no `DmemWrite`, `LoadData` unchanged. Without the macro: the same LW reads word 16.
- SB in progress: assert `Rst_n`=0 during RD_WAIT → `DmemWrite` stays 0, target word is unchanged, and after release `Stall`=0 in IDLE.
- Wrap-around: LW at `Addr`=0x1004 with `DEPTH`=1024 → `DmemAddr`=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte/half/word loads with extension, SB/SH as read-modify-write.
// Optional macro MAU_ALIGN_CHECK_EN rejects misaligned accesses; otherwise low address bits are dropped.
module mem_access_unit #(
   parameter int DEPTH = 1024
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        MemReq,
   input  logic [2:0]  MemOp,
   input  logic [31:0] Addr,
   input  logic [31:0] StoreData,
   output logic        Stall,
   output logic [31:0] LoadData,
   output logic        LoadValid,
   output logic        AlignErr,
   output logic [31:0] DmemAddr,
   output logic        DmemWrite,
   output logic [31:0] DmemWrData,
   input  logic [31:0] DmemRdData,
   output logic [1:0]  DbgState
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_SW  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;
   localparam logic [2:0] OP_SB  = 3'b110;
   localparam logic [2:0] OP_SH  = 3'b111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      DONE    = 2'd2
   } stateType;

   stateType    state, nextState;
   logic [2:0]  opQ;
   logic [AW+1:0] addrQ;
   logic [15:0] dataQ;

   logic        reqByte, reqHalf, reqWord, rejectReq;
   logic [31:0] effAddr;
   logic        qIsLoad;
   logic [7:0]  rdByte;
   logic [15:0] rdHalf;
   logic [31:0] loadExt, mergedWord;
   logic        unusedAddrBits;

   function automatic logic [31:0] wordIdx(input logic [AW-1:0] w);
      return {{(32-AW){1'b0}}, w};
   endfunction

   always_comb begin
      reqByte = 1'b0;
      reqHalf = 1'b0;
      case (MemOp)
         OP_LB, OP_LBU, OP_SB: reqByte = 1'b1;
         OP_LH, OP_LHU, OP_SH: reqHalf = 1'b1;
         default: ;
      endcase
      reqWord = !reqByte && !reqHalf;
`ifdef MAU_ALIGN_CHECK_EN
      rejectReq = (reqWord && (Addr[1:0] != 2'b00)) || (reqHalf && Addr[0]);
      effAddr   = Addr;
`else
      rejectReq = 1'b0;
      effAddr   = Addr;
      if (reqWord)
         effAddr[1:0] = 2'b00;
      else if (reqHalf)
         effAddr[0] = 1'b0;
`endif
   end

   // Bits above the memory span only cause wrap-around, so they are dropped.
   assign unusedAddrBits = ^effAddr[31:AW+2];

   assign qIsLoad = (opQ != OP_SB) && (opQ != OP_SH);

   always_comb begin
      rdByte = DmemRdData[{addrQ[1:0], 3'b000} +: 8];
      rdHalf = addrQ[1] ? DmemRdData[31:16] : DmemRdData[15:0];
      case (opQ)
         OP_LB:   loadExt = {{24{rdByte[7]}}, rdByte};
         OP_LBU:  loadExt = {24'h0, rdByte};
         OP_LH:   loadExt = {{16{rdHalf[15]}}, rdHalf};
         OP_LHU:  loadExt = {16'h0, rdHalf};
         default: loadExt = DmemRdData;
      endcase
      mergedWord = DmemRdData;
      if (opQ == OP_SB)
         mergedWord[{addrQ[1:0], 3'b000} +: 8] = dataQ[7:0];
      else if (addrQ[1])
         mergedWord[31:16] = dataQ;
      else
         mergedWord[15:0] = dataQ;
   end

   // Handshake: while Stall is high the request on MemReq/MemOp/Addr/StoreData is still in
   // service and must be held; it retires in the first cycle Stall is low (IDLE for SW or a
   // rejected access, DONE otherwise). MemReq in DONE is the retiring op and is ignored.
   always_comb begin
      nextState  = state;
      Stall      = 1'b0;
      DmemWrite  = 1'b0;
      DmemAddr   = '0;
      DmemWrData = '0;
      AlignErr   = 1'b0;
      if (Rst_n) begin
         case (state)
            IDLE: begin
               if (MemReq) begin
                  if (rejectReq) begin
                     AlignErr = 1'b1;
                  end else if (MemOp == OP_SW) begin
                     DmemWrite  = 1'b1;
                     DmemAddr   = wordIdx(effAddr[AW+1:2]);
                     DmemWrData = StoreData;
                  end else begin
                     DmemAddr  = wordIdx(effAddr[AW+1:2]);
                     Stall     = 1'b1;
                     nextState = RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               Stall     = 1'b1;
               DmemAddr  = wordIdx(addrQ[AW+1:2]);
               nextState = DONE;
               if (!qIsLoad) begin
                  DmemWrite  = 1'b1;
                  DmemWrData = mergedWord;
               end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= IDLE;
         opQ      <= '0;
         addrQ    <= '0;
         dataQ    <= '0;
         LoadData <= '0;
      end else begin
         state <= nextState;
         if (state == IDLE && nextState == RD_WAIT) begin
            opQ   <= MemOp;
            addrQ <= effAddr[AW+1:0];
            dataQ <= StoreData[15:0];
         end
         if (state == RD_WAIT && qIsLoad)
            LoadData <= loadExt;
      end
   end

   assign LoadValid = (state == DONE) && qIsLoad;
   assign DbgState  = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random ops against a
// word-array reference model; honours MAU_ALIGN_CHECK_EN when defined.
module tb_mem_access_unit;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;
`ifdef MAU_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, SW = 3'b011;
   localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, SB = 3'b110, SH = 3'b111;

   logic        Clk, Rst_n, MemReq;
   logic [2:0]  MemOp;
   logic [31:0] Addr, StoreData;
   logic        Stall, LoadValid, AlignErr, DmemWrite;
   logic [31:0] LoadData, DmemAddr, DmemWrData, DmemRdData;
   logic [1:0]  DbgState;

   logic [31:0] dmem   [DEPTH];
   logic [31:0] refMem [DEPTH];
   logic [31:0] refLoad;
   logic        preloadEn;
   logic [AW-1:0] preloadIdx;
   logic [31:0] preloadVal;

   int nChecks = 0;
   int nErrors = 0;

   mem_access_unit #(.DEPTH(DEPTH)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .MemReq(MemReq), .MemOp(MemOp), .Addr(Addr),
      .StoreData(StoreData), .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid),
      .AlignErr(AlignErr), .DmemAddr(DmemAddr), .DmemWrite(DmemWrite),
      .DmemWrData(DmemWrData), .DmemRdData(DmemRdData), .DbgState(DbgState)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Data_memory model: registered read, synchronous write
   always @(posedge Clk) begin
      if (preloadEn)
         dmem[preloadIdx] <= preloadVal;
      else if (DmemWrite)
         dmem[DmemAddr[AW-1:0]] <= DmemWrData;
      DmemRdData <= dmem[DmemAddr[AW-1:0]];
   end

   function automatic int opSize(input logic [2:0] op);
      case (op)
         LB, LBU, SB: return 1;
         LH, LHU, SH: return 2;
         default:     return 4;
      endcase
   endfunction

   function automatic bit opIsLoad(input logic [2:0] op);
      return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
   endfunction

   task automatic preload(input int idx, input logic [31:0] v);
      @(negedge Clk);
      MemReq     = 1'b0;
      preloadEn  = 1'b1;
      preloadIdx = AW'(idx);
      preloadVal = v;
      refMem[idx] = v;
      @(negedge Clk);
      preloadEn = 1'b0;
   endtask

   // driver + reference model for one operation; returns just after the retiring edge
   task automatic runOp(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
      int size, sh, idx;
      bit load, sgn, rej;
      logic [31:0] eff, word, expLoad, expWord, mask, idxW;
      size = opSize(op);
      load = opIsLoad(op);
      sgn  = (op == LB) || (op == LH);
      rej  = ALIGN_CHK && ((addr % size) != 0);
      eff  = addr - (addr % size);
      idx  = int'((eff / 4) % DEPTH);
      idxW = 32'(idx);
      sh   = int'(eff % 4) * 8;
      word = refMem[idx];
      if (size == 1) begin
         expLoad = (word >> sh) & 32'hFF;
         if (sgn && expLoad[7]) expLoad = expLoad | 32'hFFFFFF00;
         mask    = 32'hFF << sh;
         expWord = (word & ~mask) | ((data & 32'hFF) << sh);
      end else if (size == 2) begin
         expLoad = (word >> sh) & 32'hFFFF;
         if (sgn && expLoad[15]) expLoad = expLoad | 32'hFFFF0000;
         mask    = 32'hFFFF << sh;
         expWord = (word & ~mask) | ((data & 32'hFFFF) << sh);
      end else begin
         expLoad = word;
         expWord = data;
      end

      @(negedge Clk);
      MemReq = 1'b1; MemOp = op; Addr = addr; StoreData = data;
      #1;
      nChecks++;
      if (LoadData !== refLoad) begin nErrors++; $display("FAIL load_hold: got %h exp %h", LoadData, refLoad); end
      nChecks++;
      if (LoadValid !== 1'b0) begin nErrors++; $display("FAIL valid_idle: got %b exp 0", LoadValid); end
      nChecks++;
      if (AlignErr !== rej) begin nErrors++; $display("FAIL align_err: op %0d addr %h got %b exp %b", op, addr, AlignErr, rej); end

      if (rej) begin
         nChecks++;
         if (Stall !== 1'b0 || DmemWrite !== 1'b0) begin
            nErrors++; $display("FAIL reject_quiet: stall %b write %b exp 0 0", Stall, DmemWrite);
         end
      end else if (op == SW) begin
         nChecks++;
         if (Stall !== 1'b0 || DmemWrite !== 1'b1 || DmemAddr !== idxW || DmemWrData !== data) begin
            nErrors++;
            $display("FAIL sw_issue: stall %b wr %b addr %h data %h exp 0 1 %h %h",
                     Stall, DmemWrite, DmemAddr, DmemWrData, idxW, data);
         end
         refMem[idx] = data;
      end else begin
         nChecks++;
         if (Stall !== 1'b1 || DmemWrite !== 1'b0 || DmemAddr !== idxW) begin
            nErrors++;
            $display("FAIL rd_issue: stall %b wr %b addr %h exp 1 0 %h", Stall, DmemWrite, DmemAddr, idxW);
         end
         @(negedge Clk); #1;
         nChecks++;
         if (Stall !== 1'b1 || DmemWrite !== logic'(!load)) begin
            nErrors++; $display("FAIL rd_wait: stall %b wr %b exp 1 %b", Stall, DmemWrite, !load);
         end
         if (!load) begin
            nChecks++;
            if (DmemAddr !== idxW || DmemWrData !== expWord) begin
               nErrors++;
               $display("FAIL rmw_write: addr %h data %h exp %h %h", DmemAddr, DmemWrData, idxW, expWord);
            end
            refMem[idx] = expWord;
         end
         @(negedge Clk); #1;
         nChecks++;
         if (Stall !== 1'b0 || DmemWrite !== 1'b0 || LoadValid !== logic'(load)) begin
            nErrors++;
            $display("FAIL done: stall %b wr %b valid %b exp 0 0 %b", Stall, DmemWrite, LoadValid, load);
         end
         if (load) begin
            nChecks++;
            if (LoadData !== expLoad) begin
               nErrors++; $display("FAIL load_data: op %0d addr %h got %h exp %h", op, addr, LoadData, expLoad);
            end
            refLoad = expLoad;
         end
      end
      @(posedge Clk); #1;
      MemReq = 1'b0;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0; MemReq = 1'b1; MemOp = SW; Addr = 32'h40; StoreData = 32'h12345678;
      preloadEn = 1'b0; preloadIdx = '0; preloadVal = '0;
      refLoad = '0;
      repeat (2) @(negedge Clk);
      #1;
      nChecks++;
      if (Stall !== 1'b0 || DmemWrite !== 1'b0 || DmemAddr !== 32'h0 || DmemWrData !== 32'h0 ||
          LoadData !== 32'h0 || LoadValid !== 1'b0 || AlignErr !== 1'b0 || DbgState !== 2'd0) begin
         nErrors++;
         $display("FAIL reset_vals: stall %b wr %b addr %h wd %h ld %h lv %b ae %b st %0d exp all 0",
                  Stall, DmemWrite, DmemAddr, DmemWrData, LoadData, LoadValid, AlignErr, DbgState);
      end
      @(negedge Clk);
      MemReq = 1'b0;
      Rst_n  = 1'b1;
      for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
   endtask

   task automatic test_byte_load();
      preload(5, 32'h8899AABB);
      runOp(LB, 32'h15, 32'h0);
      nChecks++;
      if (LoadData !== 32'hFFFFFFAA) begin nErrors++; $display("FAIL lb_anchor: got %h exp FFFFFFAA", LoadData); end
      runOp(LBU, 32'h15, 32'h0);
      nChecks++;
      if (LoadData !== 32'h000000AA) begin nErrors++; $display("FAIL lbu_anchor: got %h exp 000000AA", LoadData); end
   endtask

   task automatic test_half_rmw();
      preload(2, 32'h11223344);
      runOp(SH, 32'h0A, 32'h0000CAFE);
      nChecks++;
      if (dmem[2] !== 32'hCAFE3344) begin nErrors++; $display("FAIL sh_anchor: got %h exp CAFE3344", dmem[2]); end
      runOp(LH, 32'h0A, 32'h0);
      nChecks++;
      if (LoadData !== 32'hFFFFCAFE) begin nErrors++; $display("FAIL lh_anchor: got %h exp FFFFCAFE", LoadData); end
   endtask

   task automatic test_store_word();
      runOp(SW, 32'h40, 32'hDEADBEEF);
      nChecks++;
      if (dmem[16] !== 32'hDEADBEEF) begin nErrors++; $display("FAIL sw_anchor: got %h exp DEADBEEF", dmem[16]); end
   endtask

   task automatic test_align_and_wrap();
      runOp(LW, 32'h42, 32'h0);
      runOp(SH, 32'h43, 32'h0000BEEF);
      runOp(LW, 32'h1004, 32'h0);
      runOp(LHU, 32'hFFFF_FFFE, 32'h0);
   endtask

   task automatic test_reset_mid_rmw();
      preload(7, 32'h55667788);
      @(negedge Clk);
      MemReq = 1'b1; MemOp = SB; Addr = 32'h1D; StoreData = 32'h000000EE;
      @(negedge Clk); #1;
      nChecks++;
      if (DmemWrite !== 1'b1) begin nErrors++; $display("FAIL rmw_pending: got %b exp 1", DmemWrite); end
      Rst_n = 1'b0;
      #1;
      nChecks++;
      if (DmemWrite !== 1'b0 || Stall !== 1'b0) begin
         nErrors++; $display("FAIL rst_mid: wr %b stall %b exp 0 0", DmemWrite, Stall);
      end
      MemReq = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      refLoad = '0;
      #1;
      nChecks++;
      if (Stall !== 1'b0 || DbgState !== 2'd0 || LoadData !== 32'h0) begin
         nErrors++; $display("FAIL rst_release: stall %b state %0d ld %h exp 0 0 0", Stall, DbgState, LoadData);
      end
      @(posedge Clk); #1;
      nChecks++;
      if (dmem[7] !== 32'h55667788) begin nErrors++; $display("FAIL rst_mem: got %h exp 55667788", dmem[7]); end
   endtask

   task automatic test_random(input int n);
      logic [2:0]  op;
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         runOp(op, a, $urandom);
      end
   endtask

   task automatic test_memory_image();
      int bad, firstBad;
      bad = 0; firstBad = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (dmem[i] !== refMem[i]) begin
            bad++;
            if (firstBad < 0) firstBad = i;
         end
      end
      nChecks++;
      if (bad != 0) begin
         nErrors++;
         $display("FAIL mem_image: %0d words differ, first idx %0d got %h exp %h",
                  bad, firstBad, dmem[firstBad], refMem[firstBad]);
      end
   endtask

   initial begin
      test_reset();
      test_byte_load();
      test_half_rmw();
      test_store_word();
      test_align_and_wrap();
      test_reset_mid_rmw();
      test_random(300);
      test_memory_image();
      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
      $finish;
   end

endmodule
